// File: rtl/sram_multiport_array.sv
// Behavioural DEPTH x DATA_W SRAM: up to two combinational read ports, optional synchronous write port.
// Optional clear engine enabled with `define SRAM_MULTIPORT_CLEAR_EN (only when HAS_WR=1).
module sram_multiport_array #(
  parameter int unsigned       ADDR_W     = 13,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       DEPTH      = 8192,
  parameter int unsigned       NUM_RD     = 2,
  parameter bit                HAS_WR     = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VALUE = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteBus,
  input  logic [ADDR_W-1:0] ReadAddress1,
  output logic [DATA_W-1:0] ReadBus1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadBus2,
  output logic              ClearBusy
);

  localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] Register [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_LIM;
  endfunction

  always_comb begin
    ReadBus1 = '0;
    if (in_range(ReadAddress1)) ReadBus1 = Register[ReadAddress1[IDX_W-1:0]];
  end

  generate
    if (NUM_RD >= 2) begin : g_rd2
      always_comb begin
        ReadBus2 = '0;
        if (in_range(ReadAddress2)) ReadBus2 = Register[ReadAddress2[IDX_W-1:0]];
      end
    end else begin : g_rd1
      assign ReadBus2 = '0;
    end
  endgenerate

`ifdef SRAM_MULTIPORT_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
`endif

  generate
    if (HAS_WR) begin : g_wr
      logic              busy;
      logic [ADDR_W-1:0] clr_addr;
`ifdef SRAM_MULTIPORT_CLEAR_EN
      clr_state_t        state, state_next;
      logic [ADDR_W-1:0] count, count_next;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state <= CLEAR;
          count <= '0;
        end else begin
          state <= state_next;
          count <= count_next;
        end
      end

      always_comb begin
        state_next = state;
        count_next = count;
        if (state == CLEAR) begin
          count_next = count + ADDR_W'(1);
          if ({1'b0, count} == LAST_IDX) state_next = IDLE;
        end
      end

      assign busy     = (state == CLEAR);
      assign clr_addr = count;
`else
      assign busy     = 1'b0;
      assign clr_addr = '0;
`endif

      // Array has no reset; reset only gates the write enable so backdoor preloads survive.
      always_ff @(posedge clock) begin
        if (reset) begin
          if (busy)
            Register[clr_addr[IDX_W-1:0]] <= FILL_VALUE;
          else if (WE && in_range(WriteAddress))
            Register[WriteAddress[IDX_W-1:0]] <= WriteBus;
        end
      end

      assign ClearBusy = busy;
    end else begin : g_ro
      assign ClearBusy = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_multiport_array.sv
// Directed bench for sram_multiport_array: ROM, dual-read, write/read, reset gating, range limits, clear engine.
module tb_sram_multiport_array;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // input memory: 1R, 8-bit, read-only
  logic        in_we = 1'b0;
  logic [12:0] in_wa = '0, in_ra1 = '0, in_ra2 = '0;
  logic [7:0]  in_wd = '0, in_rd1, in_rd2;
  logic        in_busy;
  // graph memory: 2R, 128-bit, read-only
  logic         gr_we = 1'b0;
  logic [12:0]  gr_wa = '0, gr_ra1 = '0, gr_ra2 = '0;
  logic [127:0] gr_wd = '0, gr_rd1, gr_rd2;
  logic         gr_busy;
  // output memory: 1R1W, 16-bit
  logic        out_we = 1'b0;
  logic [12:0] out_wa = '0, out_ra1 = '0, out_ra2 = '0;
  logic [15:0] out_wd = '0, out_rd1, out_rd2;
  logic        out_busy;
  // short memory for range checks: DEPTH 4096 behind 13-bit addresses
  logic        oor_we = 1'b0;
  logic [12:0] oor_wa = '0, oor_ra1 = '0, oor_ra2 = '0;
  logic [15:0] oor_wd = '0, oor_rd1, oor_rd2;
  logic        oor_busy;

`ifdef SRAM_MULTIPORT_CLEAR_EN
  localparam logic BUSY_IN_RESET = 1'b1;
`else
  localparam logic BUSY_IN_RESET = 1'b0;
`endif

  sram_multiport_array #(.ADDR_W(13), .DATA_W(8), .DEPTH(8192), .NUM_RD(1), .HAS_WR(1'b0)) u_in (
    .clock(clock), .reset(reset), .WE(in_we), .WriteAddress(in_wa), .WriteBus(in_wd),
    .ReadAddress1(in_ra1), .ReadBus1(in_rd1), .ReadAddress2(in_ra2), .ReadBus2(in_rd2),
    .ClearBusy(in_busy));

  sram_multiport_array #(.ADDR_W(13), .DATA_W(128), .DEPTH(8192), .NUM_RD(2), .HAS_WR(1'b0)) u_graph (
    .clock(clock), .reset(reset), .WE(gr_we), .WriteAddress(gr_wa), .WriteBus(gr_wd),
    .ReadAddress1(gr_ra1), .ReadBus1(gr_rd1), .ReadAddress2(gr_ra2), .ReadBus2(gr_rd2),
    .ClearBusy(gr_busy));

  sram_multiport_array #(.ADDR_W(13), .DATA_W(16), .DEPTH(8192), .NUM_RD(1), .HAS_WR(1'b1)) u_out (
    .clock(clock), .reset(reset), .WE(out_we), .WriteAddress(out_wa), .WriteBus(out_wd),
    .ReadAddress1(out_ra1), .ReadBus1(out_rd1), .ReadAddress2(out_ra2), .ReadBus2(out_rd2),
    .ClearBusy(out_busy));

  sram_multiport_array #(.ADDR_W(13), .DATA_W(16), .DEPTH(4096), .NUM_RD(2), .HAS_WR(1'b1)) u_oor (
    .clock(clock), .reset(reset), .WE(oor_we), .WriteAddress(oor_wa), .WriteBus(oor_wd),
    .ReadAddress1(oor_ra1), .ReadBus1(oor_rd1), .ReadAddress2(oor_ra2), .ReadBus2(oor_rd2),
    .ClearBusy(oor_busy));

  // Releases reset at a negedge and, with the clear engine present, waits (bounded) for it to finish.
  task automatic release_reset(output int cycles);
    cycles = 0;
    @(negedge clock);
    reset = 1'b1;
    if (BUSY_IN_RESET) begin
      for (int i = 0; i < 10000; i++) begin
        @(posedge clock);
        cycles++;
        #1;
        if (cycles == 5) begin
          out_we = 1'b1; out_wa = 13'd0; out_wd = 16'h1234;
        end else if (cycles == 6) begin
          out_we = 1'b0;
        end
        if (!out_busy) break;
      end
      checks++;
      if (out_busy !== 1'b0) begin
        errors++;
        $display("FAIL clear_timeout: ClearBusy=%b required 0 within 10000 cycles", out_busy);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_busy !== BUSY_IN_RESET) begin
      errors++; $display("FAIL reset_busy: ClearBusy=%b required %b", out_busy, BUSY_IN_RESET);
    end
    checks++;
    if (in_busy !== 1'b0) begin
      errors++; $display("FAIL reset_rom_busy: ClearBusy=%b required 0", in_busy);
    end
    checks++;
    if (in_rd2 !== 8'h00) begin
      errors++; $display("FAIL reset_rd2: ReadBus2=%h required 00", in_rd2);
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic test_clear(input int cycles);
    checks++;
    if (cycles != 8192) begin
      errors++; $display("FAIL clear_cycles: busy for %0d cycles required 8192", cycles);
    end
    out_ra1 = 13'd0; #1;
    checks++;
    if (out_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL clear_word0: got %h required ffff", out_rd1);
    end
    out_ra1 = 13'd4321; #1;
    checks++;
    if (out_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL clear_mid: got %h required ffff", out_rd1);
    end
    out_ra1 = 13'd8191; #1;
    checks++;
    if (out_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL clear_last: got %h required ffff", out_rd1);
    end
    @(negedge clock);
    out_we = 1'b1; out_wa = 13'd0; out_wd = 16'h55AA; out_ra1 = 13'd0;
    @(posedge clock); #1;
    out_we = 1'b0;
    checks++;
    if (out_rd1 !== 16'h55AA) begin
      errors++; $display("FAIL clear_post_write: got %h required 55aa", out_rd1);
    end
  endtask

  task automatic test_rom_read();
    u_in.Register[5]    <= 8'hA7;
    u_in.Register[8191] <= 8'h3C;
    #1;
    in_ra1 = 13'd5; in_ra2 = 13'd5; #1;
    checks++;
    if (in_rd1 !== 8'hA7) begin
      errors++; $display("FAIL rom_addr5: got %h required a7", in_rd1);
    end
    checks++;
    if (in_rd2 !== 8'h00) begin
      errors++; $display("FAIL rom_rd2_zero: got %h required 00", in_rd2);
    end
    in_ra1 = 13'd8191; #1;
    checks++;
    if (in_rd1 !== 8'h3C) begin
      errors++; $display("FAIL rom_addr8191: got %h required 3c", in_rd1);
    end
    @(negedge clock);
    in_we = 1'b1; in_wa = 13'd5; in_wd = 8'h00; in_ra1 = 13'd5;
    @(posedge clock); #1;
    in_we = 1'b0;
    checks++;
    if (in_rd1 !== 8'hA7) begin
      errors++; $display("FAIL rom_ignores_we: got %h required a7", in_rd1);
    end
  endtask

  task automatic test_dual_read();
    u_graph.Register[0]    <= 128'h1;
    u_graph.Register[8191] <= '1;
    #1;
    gr_ra1 = 13'd0; gr_ra2 = 13'd8191; #1;
    checks++;
    if (gr_rd1 !== 128'h1) begin
      errors++; $display("FAIL dual_p1: got %h required 1", gr_rd1);
    end
    checks++;
    if (gr_rd2 !== {128{1'b1}}) begin
      errors++; $display("FAIL dual_p2: got %h required all ones", gr_rd2);
    end
    gr_ra1 = 13'd8191; #1;
    checks++;
    if (gr_rd1 !== {128{1'b1}} || gr_rd2 !== {128{1'b1}}) begin
      errors++; $display("FAIL dual_same: p1=%h p2=%h required all ones on both", gr_rd1, gr_rd2);
    end
    gr_ra2 = 13'd0; #1;
    checks++;
    if (gr_rd2 !== 128'h1) begin
      errors++; $display("FAIL dual_p2_swap: got %h required 1", gr_rd2);
    end
  endtask

  task automatic test_write_read();
    u_out.Register[100] <= 16'h0BAD;
    #1;
    @(negedge clock);
    out_we = 1'b1; out_wa = 13'd100; out_wd = 16'h0042; out_ra1 = 13'd100;
    #1;
    checks++;
    if (out_rd1 !== 16'h0BAD) begin
      errors++; $display("FAIL wr_before_edge: got %h required 0bad", out_rd1);
    end
    @(posedge clock); #1;
    checks++;
    if (out_rd1 !== 16'h0042) begin
      errors++; $display("FAIL wr_after_edge: got %h required 0042", out_rd1);
    end
    @(negedge clock);
    out_we = 1'b0; out_wd = 16'h7777;
    @(posedge clock); #1;
    checks++;
    if (out_rd1 !== 16'h0042) begin
      errors++; $display("FAIL wr_we_low: got %h required 0042", out_rd1);
    end
  endtask

  task automatic test_reset_blocks();
    int cyc;
    logic [15:0] exp7;
`ifdef SRAM_MULTIPORT_CLEAR_EN
    exp7 = 16'hFFFF;
`else
    exp7 = 16'hBEEF;
`endif
    u_out.Register[7]  <= 16'hBEEF;
    u_out.Register[20] <= 16'hFFFF;
    u_out.Register[21] <= 16'hFFFF;
    #1;
    @(negedge clock);
    reset = 1'b0;
    out_we = 1'b1; out_wa = 13'd7; out_wd = 16'h1234; out_ra1 = 13'd7;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_busy !== BUSY_IN_RESET) begin
      errors++; $display("FAIL rst_busy: ClearBusy=%b required %b", out_busy, BUSY_IN_RESET);
    end
    checks++;
    if (out_rd1 !== 16'hBEEF) begin
      errors++; $display("FAIL rst_no_write_low: got %h required beef", out_rd1);
    end
    @(negedge clock);
    out_we = 1'b0;
    release_reset(cyc);
    #1;
    checks++;
    if (out_rd1 !== exp7) begin
      errors++; $display("FAIL rst_word7: got %h required %h", out_rd1, exp7);
    end
    out_ra1 = 13'd20; #1;
    checks++;
    if (out_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL rst_word20: got %h required ffff", out_rd1);
    end
    out_ra1 = 13'd21; #1;
    checks++;
    if (out_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL rst_word21: got %h required ffff", out_rd1);
    end
  endtask

  task automatic test_out_of_range();
    u_oor.Register[904]  <= 16'h1111;
    u_oor.Register[4095] <= 16'h2222;
    #1;
    @(negedge clock);
    oor_we = 1'b1; oor_wa = 13'd5000; oor_wd = 16'hDEAD;
    oor_ra1 = 13'd904; oor_ra2 = 13'd5000;
    @(posedge clock); #1;
    checks++;
    if (oor_rd1 !== 16'h1111) begin
      errors++; $display("FAIL oor_alias: got %h required 1111", oor_rd1);
    end
    checks++;
    if (oor_rd2 !== 16'h0000) begin
      errors++; $display("FAIL oor_read5000: got %h required 0000", oor_rd2);
    end
    oor_ra1 = 13'd4095; oor_ra2 = 13'd4096; #1;
    checks++;
    if (oor_rd1 !== 16'h2222) begin
      errors++; $display("FAIL oor_last: got %h required 2222", oor_rd1);
    end
    checks++;
    if (oor_rd2 !== 16'h0000) begin
      errors++; $display("FAIL oor_depth: got %h required 0000", oor_rd2);
    end
    @(negedge clock);
    oor_wa = 13'd4095; oor_wd = 16'h3333;
    @(posedge clock); #1;
    oor_we = 1'b0;
    checks++;
    if (oor_rd1 !== 16'h3333) begin
      errors++; $display("FAIL oor_write_last: got %h required 3333", oor_rd1);
    end
  endtask

  initial begin
    int cyc;
    test_reset();
    release_reset(cyc);
    if (BUSY_IN_RESET) test_clear(cyc);
    test_rom_read();
    test_dual_read();
    test_write_read();
    test_reset_blocks();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_multiport_array.md
Name: sram_multiport_array

Overview:
- Parameterised behavioural SRAM: DEPTH x DATA_W word array, up to two asynchronous (combinational) read ports and an optional synchronous write port.
- One RTL block covers the three memory flavours used around the Bellman-Ford engine:
  - input memory: 1R, 8-bit
  - graph memory: 2R, 128-bit
  - output memory: 1R1W, 16-bit, 0xFFFF = unreached
- The array is named Register so benches can backdoor-load and dump it with $readmemh/$writememh.

Parameters:
- ADDR_W, 13, address width of all ports.
- DATA_W, 16, word width.
- DEPTH, 8192, number of words; must be <= 2**ADDR_W.
- NUM_RD, 2, number of active read ports (1 or 2).
- HAS_WR, 1, 1 = write port active, 0 = read-only (ROM-like, contents only via backdoor).
- FILL_VALUE, all-ones of DATA_W, word written by the clear engine (optional feature).

Ports:
- clock  in  1  single clock; writes sample on rising edge.
- reset  in  1  asynchronous, active-low reset.
- WE  in  1  write enable, sampled at posedge clock.
- WriteAddress  in  ADDR_W  write word address.
- WriteBus  in  DATA_W  write data.
- ReadAddress1  in  ADDR_W  read port 1 address.
- ReadBus1  out  DATA_W  read port 1 data.
- ReadAddress2  in  ADDR_W  read port 2 address.
- ReadBus2  out  DATA_W  read port 2 data.
- ClearBusy  out  1  high while the clear engine owns the array.

Behaviour:
- Reads:
  - ReadBusN = Register[ReadAddressN], purely combinational, zero latency.
  - Updates in the same delta as an address change or array write.
  - Address >= DEPTH reads 0.
  - With NUM_RD=1, ReadBus2 is constant 0 and ReadAddress2 is ignored.
- Write:
  - At posedge clock, if HAS_WR=1, reset high, ClearBusy low, WE=1 and WriteAddress < DEPTH, then Register[WriteAddress] <= WriteBus.
  - Otherwise the array is unchanged. Out-of-range writes are silently dropped.
  - HAS_WR=0: WE/WriteAddress/WriteBus are ignored; no write logic is generated.
- Read-during-write to the same address: the read port shows old data until the clock edge, new data immediately after. No bypass.
- Both read ports may read the same address simultaneously; both return identical data.
- Reset (reset=0, asynchronous):
  - Blocks all writes while low.
  - Array contents are NOT modified by reset, so backdoor preload during reset survives.
  - ClearBusy = 0 when the optional feature is absent.
- Reset asserted mid-cycle with WE=1: no write occurs at any edge while reset is low.
- No internal FSM without the optional feature; the block is a combinational read mux plus a write decoder.
- Instance mapping:
  - input memory: NUM_RD=1, HAS_WR=0, DATA_W=8.
  - graph memory: NUM_RD=2, HAS_WR=0, DATA_W=128.
  - output memory: NUM_RD=1, HAS_WR=1, DATA_W=16, using ReadAddress1/ReadBus1.

Optional Feature:
- Macro SRAM_MULTIPORT_CLEAR_EN.
- Defined, and HAS_WR=1:
  - Adds a clear engine with states IDLE and CLEAR and a counter of ADDR_W bits.
  - reset=0 forces state CLEAR, counter 0, ClearBusy=1.
  - After reset deasserts, each posedge writes FILL_VALUE to Register[counter] and increments the counter.
  - After the write to DEPTH-1: state IDLE, ClearBusy=0. Clearing takes exactly DEPTH cycles.
  - User writes are ignored while ClearBusy=1.
  - Reads during clear return current, partially cleared contents.
  - Reset reasserted mid-clear restarts the clear from address 0.
- Not defined: no clear engine, ClearBusy tied 0, and reset never alters contents.

Test Plan:
- ROM read: 1R/8-bit instance, backdoor-load Register[5]=8'hA7, set ReadAddress1=5 -> ReadBus1=8'hA7 with zero cycles latency; ReadAddress1=8191 -> loaded value; ReadBus2=0.
- Dual read: 2R/128-bit instance, Register[0]=128'h1, Register[8191]=all-ones; ReadAddress1=0, ReadAddress2=8191 -> both buses correct concurrently; both ports at the same address -> identical data.
- Write then read: 1R1W/16-bit, reset high, WE=1, WriteAddress=100, WriteBus=16'h0042 -> before the edge ReadBus1 (address 100) shows the preload value; after the edge it shows 0042. With WE=0 the next cycle, the value is unchanged.
- Reset blocks writes: reset=0, WE=1, WriteAddress=7, WriteBus=16'h1234 over 3 edges -> Register[7] unchanged, and preloaded 16'hFFFF entries are intact after reset release.
- Out-of-range: DEPTH=4096, ADDR_W=13, write to address 5000 -> no array change; read of 5000 -> 0.
- With SRAM_MULTIPORT_CLEAR_EN: release reset -> ClearBusy=1 for exactly DEPTH cycles, then 0, and every word reads 16'hFFFF. A user write during the clear is ignored; a user write after the clear succeeds.
